gpu_fill_ctrl: RTL and testbench

- ICB master that fills an axis-aligned rectangle of the simple GPU framebuffer with one 24-bit colour, then triggers a frame sync and waits for scan-out to finish.
- Sits between a CPU-side control interface (start/geometry/colour) and the GPU's ICB slave port, typically through the bus fabric.
- Offloads pixel-by-pixel store loops from the core.

---
 rtl/gpu_pkg.sv | 37 +++
 rtl/gpu_fill_ctrl_if.sv | 29 ++
 rtl/gpu_fill_addr_gen.sv | 74 +++++++
 rtl/gpu_fill_ctrl.sv | 140 ++++++++++++++
 tb/tb_gpu_fill_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared constants for the GPU fill controller slice:
// state encoding, bus widths and the GPU register map.
package gpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    localparam logic [31:0] GPU_BASE  = 32'ha0000000;
    localparam logic [31:0] REG_CFG   = 32'h00000100;
    localparam logic [31:0] REG_SYNC  = 32'h00000104;
    localparam logic [31:0] REG_STATE = 32'h00000108;

    localparam logic [31:0] FB_BASE   = 32'ha1000000;
    localparam logic [31:0] SYNC_ADDR = GPU_BASE + REG_SYNC;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FILL     = 3'd1;
    localparam logic [2:0] ST_DRAIN    = 3'd2;
    localparam logic [2:0] ST_SYNC_CMD = 3'd3;
    localparam logic [2:0] ST_SYNC_RSP = 3'd4;
    localparam logic [2:0] ST_POLL_CMD = 3'd5;
    localparam logic [2:0] ST_POLL_RSP = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    // A 32-bit store lands in the half of the 64-bit beat picked by addr[2].
    function automatic logic [DATA_W-1:0] lane_data(
        input logic hi,
        input logic [31:0] v
    );
        return hi ? {v, 32'd0} : {32'd0, v};
    endfunction

    function automatic logic [7:0] lane_mask(input logic hi);
        return hi ? 8'hF0 : 8'h0F;
    endfunction

endpackage

// File: rtl/gpu_fill_ctrl_if.sv
// ICB command/response bundle between the fill
// controller (master) and the GPU port (slave).
interface gpu_fill_ctrl_if
    import gpu_pkg::*;
;
    logic              icb_cmd_vld;
    logic              icb_cmd_rdy;
    logic [ADDR_W-1:0] icb_cmd_addr;
    logic              icb_cmd_read;
    logic [DATA_W-1:0] icb_cmd_wdata;
    logic [7:0]        icb_cmd_wmask;
    logic              icb_rsp_vld;
    logic              icb_rsp_rdy;
    logic [DATA_W-1:0] icb_rsp_rdata;
    logic              icb_rsp_err;

    modport master (
        output icb_cmd_vld, icb_cmd_addr, icb_cmd_read,
        output icb_cmd_wdata, icb_cmd_wmask, icb_rsp_rdy,
        input  icb_cmd_rdy, icb_rsp_vld, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_vld, icb_cmd_addr, icb_cmd_read,
        input  icb_cmd_wdata, icb_cmd_wmask, icb_rsp_rdy,
        output icb_cmd_rdy, icb_rsp_vld, icb_rsp_rdata, icb_rsp_err
    );

endinterface

// File: rtl/gpu_fill_addr_gen.sv
// Raster walker over the clipped rectangle; the row base
// is accumulated so the per-pixel path has no multiplier.
module gpu_fill_addr_gen
    import gpu_pkg::*;
#(
    parameter int SCR_W = 320
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    input  logic [15:0] x0,
    input  logic [15:0] y0,
    input  logic [16:0] xe,
    input  logic [16:0] ye,
    output logic [31:0] addr,
    output logic        last
);

    logic [16:0] x_q, x_d;
    logic [16:0] y_q, y_d;
    logic [16:0] xs_q, xs_d;
    logic [16:0] xe_q, xe_d;
    logic [16:0] ye_q, ye_d;
    logic [31:0] row_q, row_d;
    logic        x_end;

    always_comb begin
        x_end = (x_q == xe_q - 17'd1);
        last  = x_end && (y_q == ye_q - 17'd1);
        addr  = FB_BASE + ((row_q + 32'(x_q)) << 2);
        x_d   = x_q;
        y_d   = y_q;
        xs_d  = xs_q;
        xe_d  = xe_q;
        ye_d  = ye_q;
        row_d = row_q;
        if (load) begin
            x_d   = {1'b0, x0};
            y_d   = {1'b0, y0};
            xs_d  = {1'b0, x0};
            xe_d  = xe;
            ye_d  = ye;
            row_d = 32'(y0) * 32'(SCR_W);
        end else if (adv) begin
            if (x_end) begin
                x_d   = xs_q;
                y_d   = y_q + 17'd1;
                row_d = row_q + 32'(SCR_W);
            end else begin
                x_d = x_q + 17'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            xs_q  <= '0;
            xe_q  <= '0;
            ye_q  <= '0;
            row_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            xs_q  <= xs_d;
            xe_q  <= xe_d;
            ye_q  <= ye_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/gpu_fill_ctrl.sv
// Rectangle fill engine: streams pixel stores over ICB,
// then kicks the GPU sync register and optionally polls it.
module gpu_fill_ctrl
    import gpu_pkg::*;
#(
    parameter int SCR_W    = 320,
    parameter int SCR_H    = 240,
    parameter int MAX_OUTS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [15:0]            x0,
    input  logic [15:0]            y0,
    input  logic [15:0]            w,
    input  logic [15:0]            h,
    input  logic [23:0]            color,
    input  logic                   wait_sync,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    gpu_fill_ctrl_if.master        icb
);

    localparam int CW = $clog2(MAX_OUTS) + 1;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] outs_q, outs_d;
    logic          err_q, err_d;
    logic          wait_q, wait_d;
    logic [23:0]   color_q, color_d;
    logic [16:0]   xs, ys, xe, ye;
    logic          empty, go, hs, pix_hs, dec;
    logic [31:0]   pix_addr;
    logic          pix_last;
    logic          poll_bit;
    logic          unused_rdata;

    gpu_fill_addr_gen #(.SCR_W(SCR_W)) u_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (go),
        .adv   (pix_hs),
        .x0    (x0),
        .y0    (y0),
        .xe    (xe),
        .ye    (ye),
        .addr  (pix_addr),
        .last  (pix_last)
    );

    always_comb begin
        xs    = {1'b0, x0} + {1'b0, w};
        ys    = {1'b0, y0} + {1'b0, h};
        xe    = (xs > 17'(SCR_W)) ? 17'(SCR_W) : xs;
        ye    = (ys > 17'(SCR_H)) ? 17'(SCR_H) : ys;
        // x0 >= xe covers both w == 0 and x0 past the right edge
        empty = ({1'b0, x0} >= xe) || ({1'b0, y0} >= ye);
        go    = start && (state_q == ST_IDLE);

        icb.icb_rsp_rdy   = 1'b1;
        icb.icb_cmd_vld   = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = '0;
        unique case (state_q)
            ST_FILL: begin
                icb.icb_cmd_vld   = outs_q < CW'(MAX_OUTS);
                icb.icb_cmd_addr  = pix_addr;
                icb.icb_cmd_wdata = lane_data(pix_addr[2], {8'd0, color_q});
                icb.icb_cmd_wmask = lane_mask(pix_addr[2]);
            end
            ST_SYNC_CMD: begin
                icb.icb_cmd_vld   = 1'b1;
                icb.icb_cmd_addr  = SYNC_ADDR;
                icb.icb_cmd_wdata = lane_data(SYNC_ADDR[2], 32'd1);
                icb.icb_cmd_wmask = lane_mask(SYNC_ADDR[2]);
            end
            ST_POLL_CMD: begin
                icb.icb_cmd_vld  = 1'b1;
                icb.icb_cmd_addr = SYNC_ADDR;
                icb.icb_cmd_read = 1'b1;
            end
            default: ;
        endcase

        hs       = icb.icb_cmd_vld && icb.icb_cmd_rdy;
        pix_hs   = hs && (state_q == ST_FILL);
        dec      = icb.icb_rsp_vld && (outs_q != '0);
        outs_d   = outs_q + CW'(hs) - CW'(dec);
        err_d    = (go ? 1'b0 : err_q) | (icb.icb_rsp_vld & icb.icb_rsp_err);
        wait_d   = go ? wait_sync : wait_q;
        color_d  = go ? color : color_q;
        poll_bit = SYNC_ADDR[2] ? icb.icb_rsp_rdata[32]
                                : icb.icb_rsp_rdata[0];
        unused_rdata = ^icb.icb_rsp_rdata;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (go) state_d = empty ? ST_SYNC_CMD : ST_FILL;
            ST_FILL:     if (pix_hs && pix_last) state_d = ST_DRAIN;
            ST_DRAIN:    if (outs_q == '0) state_d = ST_SYNC_CMD;
            ST_SYNC_CMD: if (hs) state_d = ST_SYNC_RSP;
            ST_SYNC_RSP: if (icb.icb_rsp_vld)
                             state_d = wait_q ? ST_POLL_CMD : ST_DONE;
            ST_POLL_CMD: if (hs) state_d = ST_POLL_RSP;
            ST_POLL_RSP: if (icb.icb_rsp_vld)
                             state_d = poll_bit ? ST_POLL_CMD : ST_DONE;
            default:     state_d = ST_IDLE;
        endcase

        busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done = (state_q == ST_DONE);
        err  = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            outs_q  <= '0;
            err_q   <= 1'b0;
            wait_q  <= 1'b0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            color_q <= color_d;
        end
    end

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        icb.icb_rsp_vld |-> (outs_q != '0));

    a_outs_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outs_q <= CW'(MAX_OUTS));

endmodule

// File: tb/tb_gpu_fill_ctrl.sv
// Directed and randomized fill runs against a
// rectangle/queue reference model of the ICB traffic.
module tb_gpu_fill_ctrl;

    localparam int SW = 16;
    localparam int SH = 8;
    localparam int MO = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic [7:0]  mask;
        logic [63:0] data;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x0 = '0, y0 = '0, w = '0, h = '0;
    logic [23:0] color = '0;
    logic        wait_sync = 1'b0;
    logic        busy, done, err;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int rdy_pct = 100;
    int lat = 1;
    int err_at = 0;
    int rsp_n = 0;
    int poll_ones = 0;
    int inflight = 0;
    logic prev_stall = 1'b0;
    cmd_t cur, prev_cmd;
    cmd_t hs_q[$];
    cmd_t exp_q[$];
    int   due_q[$];
    logic [63:0] rd_q[$];

    gpu_fill_ctrl_if bus ();

    gpu_fill_ctrl #(
        .SCR_W(SW), .SCR_H(SH), .MAX_OUTS(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h), .color(color),
        .wait_sync(wait_sync), .busy(busy), .done(done), .err(err),
        .icb(bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t norm(input cmd_t c);
        cmd_t r = c;
        if (r.rd) r.data = '0;
        return r;
    endfunction

    // Expected command stream straight from the rectangle definition.
    task automatic build(input int ax, input int ay, input int aw,
                         input int ah, input logic [23:0] c,
                         input logic ws, input int polls);
        int xe, ye;
        logic [31:0] a;
        cmd_t e;
        exp_q.delete();
        xe = (ax + aw < SW) ? ax + aw : SW;
        ye = (ay + ah < SH) ? ay + ah : SH;
        for (int y = ay; y < ye; y++) begin
            for (int x = ax; x < xe; x++) begin
                a = 32'ha1000000 + 32'((y * SW + x) * 4);
                e.addr = a;
                e.rd   = 1'b0;
                if (a[2]) begin
                    e.mask = 8'hF0;
                    e.data = {8'd0, c, 32'd0};
                end else begin
                    e.mask = 8'h0F;
                    e.data = {32'd0, 8'd0, c};
                end
                exp_q.push_back(e);
            end
        end
        exp_q.push_back({32'ha0000104, 1'b0, 8'hF0, 64'h1_0000_0000});
        if (ws) begin
            for (int i = 0; i <= polls; i++)
                exp_q.push_back({32'ha0000104, 1'b1, 8'h00, 64'd0});
        end
    endtask

    // Bus slave: random ready, fixed-latency in-order responses.
    initial begin
        bus.icb_cmd_rdy   = 1'b0;
        bus.icb_rsp_vld   = 1'b0;
        bus.icb_rsp_rdata = '0;
        bus.icb_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                due_q.delete();
                rd_q.delete();
                inflight = 0;
                prev_stall = 1'b0;
                bus.icb_rsp_vld = 1'b0;
                bus.icb_rsp_err = 1'b0;
                bus.icb_cmd_rdy = 1'b0;
            end else begin
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    void'(due_q.pop_front());
                    bus.icb_rsp_rdata = rd_q.pop_front();
                    bus.icb_rsp_vld = 1'b1;
                    rsp_n++;
                    bus.icb_rsp_err = (rsp_n == err_at);
                    inflight--;
                end else begin
                    bus.icb_rsp_vld   = 1'b0;
                    bus.icb_rsp_err   = 1'b0;
                    bus.icb_rsp_rdata = '0;
                end
                bus.icb_cmd_rdy = ($urandom_range(99, 0) < rdy_pct);
                #1;
                cur = {bus.icb_cmd_addr, bus.icb_cmd_read,
                       bus.icb_cmd_wmask, bus.icb_cmd_wdata};
                if (prev_stall)
                    chk("stable", 128'({bus.icb_cmd_vld, cur}),
                        128'({1'b1, prev_cmd}));
                if (bus.icb_cmd_vld && bus.icb_cmd_rdy) begin
                    hs_q.push_back(cur);
                    due_q.push_back(cyc + lat);
                    if (cur.rd && poll_ones > 0) begin
                        rd_q.push_back(64'h1_0000_0000);
                        poll_ones--;
                    end else begin
                        rd_q.push_back(64'd0);
                    end
                    inflight++;
                    chk("outstanding", 128'(inflight <= MO), 128'(1));
                end
                prev_stall = bus.icb_cmd_vld && !bus.icb_cmd_rdy;
                prev_cmd = cur;
            end
        end
    end

    task automatic run(input int ax, input int ay, input int aw,
                       input int ah, input logic [23:0] c,
                       input logic ws, input int polls, input int eat,
                       input int pct, input int l);
        logic got;
        int n;
        build(ax, ay, aw, ah, c, ws, polls);
        @(negedge clk);
        hs_q.delete();
        rsp_n = 0;
        err_at = eat;
        poll_ones = polls;
        rdy_pct = pct;
        lat = l;
        x0 = 16'(ax); y0 = 16'(ay); w = 16'(aw); h = 16'(ah);
        color = c;
        wait_sync = ws;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("err_cleared", 128'(err), 128'(0));
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            #2;
            if (done) got = 1'b1;
        end
        chk("done_seen", 128'(got), 128'(1));
        chk("busy_at_done", 128'(busy), 128'(0));
        chk("err_at_done", 128'(err), 128'(eat > 0));
        chk("ncmd", 128'(hs_q.size()), 128'(exp_q.size()));
        n = (hs_q.size() < exp_q.size()) ? hs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("cmd%0d", i), 128'(norm(hs_q[i])),
                128'(exp_q[i]));
        @(negedge clk);
        #2;
        chk("done_pulse", 128'(done), 128'(0));
    endtask

    initial begin
        int rx, ry, rw, rh;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_vld", 128'(bus.icb_cmd_vld), 128'(0));
        rst_n = 1'b1;

        run(0, 0, 2, 2, 24'h123456, 1'b0, 0, 0, 100, 1);
        run(SW - 1, 0, 3, 1, 24'hABCDEF, 1'b0, 0, 0, 100, 1);
        run(3, 3, 0, 4, 24'h00FF00, 1'b0, 0, 0, 100, 1);
        run(2, SH, 4, 2, 24'h0000FF, 1'b0, 0, 0, 100, 1);

        for (int k = 0; k < 6; k++) begin
            rx = $urandom_range(SW + 1, 0);
            ry = $urandom_range(SH + 1, 0);
            rw = $urandom_range(7, 0);
            rh = $urandom_range(4, 0);
            run(rx, ry, rw, rh, 24'($urandom), 1'b0, 0, 0, 50, 3);
        end
        run(0, 0, SW, SH, 24'h5A5A5A, 1'b0, 0, 0, 50, 3);

        run(1, 1, 1, 1, 24'h777777, 1'b1, 3, 0, 50, 3);
        run(2, 2, 3, 2, 24'h010203, 1'b0, 0, 2, 100, 3);
        run(0, 0, 1, 1, 24'h040506, 1'b0, 0, 0, 100, 1);

        @(negedge clk);
        rdy_pct = 100;
        lat = 3;
        err_at = 0;
        x0 = 0; y0 = 0; w = 16'(SW); h = 16'(SH);
        wait_sync = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_vld", 128'(bus.icb_cmd_vld), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(4, 5, 2, 1, 24'h999999, 1'b0, 0, 0, 50, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
